// File: rtl/dense_mul.sv
// dense_mul: streaming 4x4 signed 32-bit matrix multiplier (C = A x B).
// Loads A and B one element per clock in row-major order. It then computes
// two adjacent C elements per 4-cycle window using two multiply-accumulate
// lanes, and emits each result pair with a one-cycle valid pulse.
module dense_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] datain1,
  input  logic [31:0] datain2,
  output logic [63:0] dataout1,
  output logic [63:0] dataout2,
  output logic        valid
);

  typedef enum logic {
    LOAD = 1'b0,
    COMP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  n_q, n_d;       // element index while loading
  logic [2:0]  p_q, p_d;       // output pair index while computing
  logic [1:0]  k_q, k_d;       // inner-product step while computing
  logic [63:0] acc1_q, acc1_d;
  logic [63:0] acc2_q, acc2_d;
  logic [63:0] out1_q, out1_d;
  logic [63:0] out2_q, out2_d;
  logic        valid_q, valid_d;

  logic [31:0] a_q [16];
  logic [31:0] a_d [16];
  logic [31:0] b_q [16];
  logic [31:0] b_d [16];

  logic [3:0]         a_idx, b1_idx, b2_idx;
  logic signed [31:0] a_el, b1_el, b2_el;
  logic signed [63:0] prod1, prod2;
  logic [63:0]        sum1, sum2;

  // Control state, counters, accumulators and outputs; cleared by async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      n_q     <= '0;
      p_q     <= '0;
      k_q     <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_q     <= p_d;
      k_q     <= k_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      valid_q <= valid_d;
    end
  end

  // Matrix storage; never reset because every load fully rewrites it
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  // Next-state: 16 load cycles, then 8 pairs x 4 steps of compute
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: if (n_q == 4'd15) state_d = COMP;
      COMP: if ((k_q == 2'd3) && (p_q == 3'd7)) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Element capture while loading; inputs are ignored during compute
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (state_q == LOAD) begin
      a_d[n_q] = datain1;
      b_d[n_q] = datain2;
    end
  end

  // Operand selection: row r = p/2, columns c = 2*(p%2) and c+1, step k
  always_comb begin
    a_idx  = {p_q[2:1], k_q};
    b1_idx = {k_q, p_q[0], 1'b0};
    b2_idx = {k_q, p_q[0], 1'b1};
    a_el   = a_q[a_idx];
    b1_el  = b_q[b1_idx];
    b2_el  = b_q[b2_idx];
    prod1  = 64'(a_el) * 64'(b1_el);
    prod2  = 64'(a_el) * 64'(b2_el);
    sum1   = acc1_q + prod1;
    sum2   = acc2_q + prod2;
  end

  // Datapath outputs: counter advance, accumulation and result emission
  always_comb begin
    n_d     = n_q;
    p_d     = p_q;
    k_d     = k_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    valid_d = 1'b0;
    unique case (state_q)
      LOAD: begin
        // wraps to 0 on the last element so compute starts with n = 0
        n_d = n_q + 4'd1;
      end
      COMP: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          out1_d  = sum1;
          out2_d  = sum2;
          valid_d = 1'b1;
          acc1_d  = '0;
          acc2_d  = '0;
          p_d     = p_q + 3'd1;
        end else begin
          acc1_d = sum1;
          acc2_d = sum2;
        end
      end
      default: begin
        n_d = '0;
      end
    endcase
  end

  assign dataout1 = out1_q;
  assign dataout2 = out2_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_dense_mul.sv
// Testbench for dense_mul: table of matrix problems with expected C,
// scoreboard of result pairs, plus reset-in-LOAD and reset-in-COMP sequences.
module tb_dense_mul;

  logic        clk;
  logic        rst;
  logic [31:0] datain1;
  logic [31:0] datain2;
  logic [63:0] dataout1;
  logic [63:0] dataout2;
  logic        valid;

  dense_mul dut (
    .clk      (clk),
    .rst      (rst),
    .datain1  (datain1),
    .datain2  (datain2),
    .dataout1 (dataout1),
    .dataout2 (dataout2),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][31:0] a;
    logic [15:0][31:0] b;
    logic [15:0][63:0] c;
  } vec_t;

  typedef logic [127:0] pair_t;

  vec_t  tbl [7];
  pair_t sb [$];
  int    n_cmp;
  int    n_err;
  logic [63:0] last1;
  logic [63:0] last2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: plain signed matrix product, wrapping at 64 bits
  task automatic ref_mul(inout vec_t v);
    longint s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++) begin
          s += longint'(signed'(v.a[4*r+k])) * longint'(signed'(v.b[4*k+c]));
        end
        v.c[4*r+c] = s;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_d1", dataout1, 64'd0);
    check("rst_d2", dataout2, 64'd0);
    last1 = '0;
    last2 = '0;
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Drives 16 elements (one per edge) and queues the 8 expected result pairs
  task automatic load_problem(input vec_t v, input int n_elems);
    int r;
    int c;
    for (int p = 0; p < 8; p++) begin
      r = p / 2;
      c = 2 * (p % 2);
      sb.push_back({v.c[4*r+c], v.c[4*r+c+1]});
    end
    for (int n = 0; n < n_elems; n++) begin
      datain1 = v.a[n];
      datain2 = v.b[n];
      @(posedge clk);
      #1;
      check("load_valid", {63'd0, valid}, 64'd0);
    end
    datain1 = $urandom;
    datain2 = $urandom;
  endtask

  // Steps through compute edges; valid must pulse on every 4th edge only
  task automatic comp_phase(input int n_edges);
    pair_t e;
    for (int i = 0; i < n_edges; i++) begin
      datain1 = $urandom;
      datain2 = $urandom;
      @(posedge clk);
      #1;
      check("comp_valid", {63'd0, valid}, {63'd0, (i % 4) == 3});
      if (valid) begin
        if (sb.size() == 0) begin
          check("sb_empty", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("dataout1", dataout1, e[127:64]);
          check("dataout2", dataout2, e[63:0]);
          last1 = e[127:64];
          last2 = e[63:0];
        end
      end else begin
        check("hold_d1", dataout1, last1);
        check("hold_d2", dataout2, last2);
      end
    end
  endtask

  initial begin
    vec_t junk;
    rst     = 1'b1;
    datain1 = '0;
    datain2 = '0;
    n_cmp   = 0;
    n_err   = 0;
    last1   = '0;
    last2   = '0;

    // Table: identity, all ones, signed extremes, back-to-back pair, random
    for (int i = 0; i < 7; i++) tbl[i] = '0;
    for (int n = 0; n < 16; n++) begin
      tbl[0].a[n] = (n % 5 == 0) ? 32'd1 : 32'd0;
      tbl[0].b[n] = 32'(n + 1);
      tbl[0].c[n] = 64'(n + 1);
      tbl[1].a[n] = 32'd1;
      tbl[1].b[n] = 32'd1;
      tbl[1].c[n] = 64'd4;
      tbl[2].a[n] = 32'h8000_0000;
      tbl[2].b[n] = 32'h8000_0000;
      tbl[2].c[n] = 64'd0;
      tbl[3].a[n] = 32'h7FFF_FFFF;
      tbl[3].b[n] = 32'hFFFF_FFFF;
      tbl[3].c[n] = 64'hFFFF_FFFE_0000_0004;
      tbl[4].a[n] = (n % 5 == 0) ? 32'd1 : 32'd0;
      tbl[4].b[n] = 32'd2;
      tbl[4].c[n] = 64'd2;
      tbl[5].a[n] = (n % 5 == 0) ? 32'd2 : 32'd0;
      tbl[5].b[n] = 32'd3;
      tbl[5].c[n] = 64'd6;
      tbl[6].a[n] = $urandom;
      tbl[6].b[n] = $urandom;
    end
    ref_mul(tbl[6]);

    #1;
    check("init_valid", {63'd0, valid}, 64'd0);
    check("init_d1", dataout1, 64'd0);
    check("init_d2", dataout2, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Table problems streamed back to back
    for (int i = 0; i < 7; i++) begin
      load_problem(tbl[i], 16);
      comp_phase(32);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Reset mid-COMP after the first pulse, then full identity reload
    do_reset();
    load_problem(tbl[0], 16);
    comp_phase(8);
    #1 rst = 1'b1;
    #1;
    check("midcomp_valid", {63'd0, valid}, 64'd0);
    check("midcomp_d1", dataout1, 64'd0);
    check("midcomp_d2", dataout2, 64'd0);
    sb.delete();
    last1 = '0;
    last2 = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    load_problem(tbl[0], 16);
    comp_phase(32);

    // Reset mid-LOAD after 7 junk elements, then all-ones reload
    for (int n = 0; n < 16; n++) begin
      junk.a[n] = $urandom;
      junk.b[n] = $urandom;
    end
    junk.c = '0;
    load_problem(junk, 7);
    sb.delete();
    do_reset();
    load_problem(tbl[1], 16);
    comp_phase(32);
    check("sb_final", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
